// File: rtl/key_event_capture_if.sv
// Avalon-MM slave port bundle for key_event_capture: word address, strobes, write and read data.
interface key_event_capture_if;
  logic [1:0]  avs_address;
  logic        avs_read;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic [31:0] avs_readdata;

  modport master (
    output avs_address, avs_read, avs_write, avs_writedata,
    input  avs_readdata
  );

  modport slave (
    input  avs_address, avs_read, avs_write, avs_writedata,
    output avs_readdata
  );
endinterface

// File: rtl/key_event_capture.sv
// Debounced key levels -> per-key press flags, mask, press counter and level irq on Avalon-MM.
// Latency: key press to capture flag / irq 1 clk; avs_readdata valid 1 clk after avs_read.
// Backpressure: none, the slave accepts every access; long-press events exist only with KEY_LONGPRESS_EN.
module key_event_capture #(
  parameter int WIDTH      = 4,
  parameter     POLARITY   = "LOW",
  parameter int HOLD_TICKS = 25000000,
  parameter int HOLD_WIDTH = 25
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [WIDTH-1:0]    data_in,
  key_event_capture_if.slave  avs,
  output logic                irq
);

  localparam bit ACTIVE_LOW = (POLARITY == "LOW");

  logic [WIDTH-1:0] pressed;
  logic [WIDTH-1:0] prev;
  logic             prime;
  logic [WIDTH-1:0] press_edge;
  logic [WIDTH-1:0] cap;
  logic [WIDTH-1:0] cap_clr;
  logic [WIDTH-1:0] mask;
  logic [WIDTH-1:0] lcap;
  logic [7:0]       count;
  logic [7:0]       edge_cnt;
  logic [31:0]      rd_mux;
  logic [31:0]      readdata;
  logic             wr_mask;
  logic             wr_cap;
  logic             wr_count;
  logic             unused_wd;

  assign pressed    = ACTIVE_LOW ? ~data_in : data_in;
  // prime masks the first cycle after reset so a key held through reset is not a press
  assign press_edge = pressed & ~prev & {WIDTH{prime}};

  assign wr_mask  = avs.avs_write && (avs.avs_address == 2'd1);
  assign wr_cap   = avs.avs_write && (avs.avs_address == 2'd2);
  assign wr_count = avs.avs_write && (avs.avs_address == 2'd3);
  assign cap_clr  = wr_cap ? avs.avs_writedata[WIDTH-1:0] : '0;
  assign unused_wd = ^avs.avs_writedata;

  always_comb begin
    edge_cnt = '0;
    for (int i = 0; i < WIDTH; i++) begin
      edge_cnt = edge_cnt + 8'(press_edge[i]);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev  <= '0;
      prime <= 1'b0;
      cap   <= '0;
      mask  <= '0;
      count <= '0;
    end else begin
      prev  <= pressed;
      prime <= 1'b1;
      cap   <= (cap & ~cap_clr) | press_edge;
      if (wr_mask) begin
        mask <= avs.avs_writedata[WIDTH-1:0];
      end
      // a write clears first, this cycle's edges still count
      count <= (wr_count ? 8'd0 : count) + edge_cnt;
    end
  end

`ifdef KEY_LONGPRESS_EN
  logic [HOLD_WIDTH-1:0] hold_cnt [WIDTH];
  logic [WIDTH-1:0]      armed;
  logic [WIDTH-1:0]      hold_hit;
  logic [WIDTH-1:0]      lcap_q;
  logic [WIDTH-1:0]      lcap_clr;

  assign lcap_clr = wr_cap ? avs.avs_writedata[WIDTH+7:8] : '0;
  assign lcap     = lcap_q;

  // hit fires on the cycle the counter steps into HOLD_TICKS-1, then it saturates
  always_comb begin
    hold_hit = '0;
    for (int i = 0; i < WIDTH; i++) begin
      hold_hit[i] = armed[i] & pressed[i] & ~press_edge[i] &
                    (hold_cnt[i] == HOLD_WIDTH'(HOLD_TICKS - 2));
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < WIDTH; i++) begin
        hold_cnt[i] <= '0;
      end
      armed  <= '0;
      lcap_q <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (!pressed[i] || press_edge[i]) begin
          hold_cnt[i] <= '0;
        end else if (armed[i] && (hold_cnt[i] != HOLD_WIDTH'(HOLD_TICKS - 1))) begin
          hold_cnt[i] <= hold_cnt[i] + 1'b1;
        end
        if (press_edge[i]) begin
          armed[i] <= 1'b1;
        end else if (!pressed[i]) begin
          armed[i] <= 1'b0;
        end
      end
      lcap_q <= (lcap_q & ~lcap_clr) | hold_hit;
    end
  end
`else
  assign lcap = '0;
`endif

  always_comb begin
    rd_mux = '0;
    case (avs.avs_address)
      2'd0: rd_mux[WIDTH-1:0] = pressed;
      2'd1: rd_mux[WIDTH-1:0] = mask;
      2'd2: begin
        rd_mux[WIDTH-1:0]  = cap;
        rd_mux[WIDTH+7:8]  = lcap;
      end
      default: rd_mux[7:0] = count;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= '0;
    end else if (avs.avs_read) begin
      readdata <= rd_mux;
    end
  end

  assign avs.avs_readdata = readdata;
  assign irq = |((cap | lcap) & mask);

endmodule

// File: tb/tb_key_event_capture.sv
// Self-checking bench for key_event_capture: directed scenarios plus random traffic against a behavioural model.
module tb_key_event_capture;
  localparam int HT = 10;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] data_in = 4'hF;
  logic       irq;

  key_event_capture_if bus();

  key_event_capture #(.WIDTH(4), .POLARITY("LOW"), .HOLD_TICKS(HT), .HOLD_WIDTH(4)) dut (
    .clk(clk), .reset_n(reset_n), .data_in(data_in), .avs(bus), .irq(irq)
  );

  always #5 clk = ~clk;

  logic [3:0]  m_prev, m_cap, m_mask, m_lcap;
  bit          m_prime;
  int          m_count;
  int          m_held [4];
  logic [31:0] m_rd;
  int          n_checks = 0;
  int          n_fail = 0;

  function automatic logic m_irq();
    return |((m_cap | m_lcap) & m_mask);
  endfunction

  // One clock of stimulus; the model advances using the values the DUT sees at this edge.
  task automatic step(input logic [3:0] d, input bit rd, input bit wr, input logic [1:0] a, input logic [31:0] wd);
    logic [3:0] p, e;
    data_in = d; bus.avs_read = rd; bus.avs_write = wr; bus.avs_address = a; bus.avs_writedata = wd;
    p = ~d;
    e = m_prime ? (p & ~m_prev) : 4'h0;
    if (rd) begin
      m_rd = 32'h0;
      case (a)
        2'd0: m_rd[3:0] = p;
        2'd1: m_rd[3:0] = m_mask;
        2'd2: begin m_rd[3:0] = m_cap; m_rd[11:8] = m_lcap; end
        default: m_rd[7:0] = 8'(m_count);
      endcase
    end
    if (wr && a == 2'd1) m_mask = wd[3:0];
    if (wr && a == 2'd2) begin
      m_cap = m_cap & ~wd[3:0];
`ifdef KEY_LONGPRESS_EN
      m_lcap = m_lcap & ~wd[11:8];
`endif
    end
    if (wr && a == 2'd3) m_count = 0;
    m_cap = m_cap | e;
    m_count = (m_count + $countones(e)) % 256;
`ifdef KEY_LONGPRESS_EN
    for (int i = 0; i < 4; i++) begin
      if (e[i]) m_held[i] = 1;
      else if (!p[i]) m_held[i] = 0;
      else if (m_held[i] > 0) m_held[i] = m_held[i] + 1;
      if (m_held[i] == HT) m_lcap[i] = 1'b1;
    end
`endif
    m_prev = p; m_prime = 1'b1;
    @(posedge clk); #1;
    bus.avs_read = 1'b0; bus.avs_write = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; data_in = 4'b1110;
    bus.avs_read = 1'b0; bus.avs_write = 1'b0; bus.avs_address = 2'd0; bus.avs_writedata = 32'h0;
    m_prev = 4'h0; m_cap = 4'h0; m_mask = 4'h0; m_lcap = 4'h0; m_prime = 1'b0; m_count = 0; m_rd = 32'h0;
    for (int i = 0; i < 4; i++) m_held[i] = 0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq_held: got %b expected 0", irq); end
    n_checks++; if (bus.avs_readdata !== 32'h0) begin n_fail++; $display("FAIL reset_readdata: got %h expected 0", bus.avs_readdata); end
    reset_n = 1'b1;
    step(4'hE, 0, 0, 2'd0, 32'h0);
    step(4'hE, 1, 0, 2'd0, 32'h0);
    n_checks++; if (bus.avs_readdata !== 32'h1) begin n_fail++; $display("FAIL reset_status: got %h expected 1", bus.avs_readdata); end
    step(4'hE, 1, 0, 2'd2, 32'h0);
    n_checks++; if (bus.avs_readdata !== 32'h0) begin n_fail++; $display("FAIL reset_capture: got %h expected 0", bus.avs_readdata); end
    step(4'hE, 1, 0, 2'd3, 32'h0);
    n_checks++; if (bus.avs_readdata !== 32'h0) begin n_fail++; $display("FAIL reset_count: got %h expected 0", bus.avs_readdata); end
    step(4'hE, 1, 0, 2'd1, 32'h0);
    n_checks++; if (bus.avs_readdata !== 32'h0) begin n_fail++; $display("FAIL reset_mask: got %h expected 0", bus.avs_readdata); end
    n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq: got %b expected 0", irq); end
  endtask

  task automatic test_press();
    step(4'hF, 0, 1, 2'd1, 32'hF);
    step(4'hF, 0, 0, 2'd0, 32'h0);
    n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL press_idle_irq: got %b expected 0", irq); end
    step(4'hE, 0, 0, 2'd0, 32'h0);
    n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL press_irq: got %b expected 1", irq); end
    step(4'hE, 1, 0, 2'd2, 32'h0);
    n_checks++; if (bus.avs_readdata !== 32'h1) begin n_fail++; $display("FAIL press_capture: got %h expected 1", bus.avs_readdata); end
    step(4'hE, 1, 0, 2'd3, 32'h0);
    n_checks++; if (bus.avs_readdata !== 32'h1) begin n_fail++; $display("FAIL press_count: got %h expected 1", bus.avs_readdata); end
    step(4'hE, 0, 1, 2'd2, 32'h1);
    n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL press_w1c_irq: got %b expected 0", irq); end
  endtask

  task automatic test_multi();
    step(4'hF, 0, 1, 2'd3, 32'h0);
    step(4'h0, 0, 0, 2'd0, 32'h0);
    step(4'h0, 1, 0, 2'd2, 32'h0);
    n_checks++; if (bus.avs_readdata !== 32'hF) begin n_fail++; $display("FAIL multi_capture: got %h expected f", bus.avs_readdata); end
    step(4'h0, 1, 0, 2'd3, 32'h0);
    n_checks++; if (bus.avs_readdata !== 32'h4) begin n_fail++; $display("FAIL multi_count: got %h expected 4", bus.avs_readdata); end
    step(4'h0, 0, 1, 2'd1, 32'h2);
    step(4'h0, 0, 1, 2'd2, 32'h2);
    n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL multi_mask_irq: got %b expected 0", irq); end
    step(4'h0, 1, 0, 2'd2, 32'h0);
    n_checks++; if (bus.avs_readdata !== 32'hD) begin n_fail++; $display("FAIL multi_w1c: got %h expected d", bus.avs_readdata); end
  endtask

  task automatic test_race();
    step(4'hF, 0, 1, 2'd2, 32'hF);
    step(4'hF, 0, 1, 2'd1, 32'hF);
    step(4'hE, 0, 1, 2'd2, 32'h1);
    step(4'hE, 1, 0, 2'd2, 32'h0);
    n_checks++; if (bus.avs_readdata !== 32'h1) begin n_fail++; $display("FAIL race_set_wins: got %h expected 1", bus.avs_readdata); end
    n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL race_irq: got %b expected 1", irq); end
    step(4'h6, 0, 1, 2'd3, 32'h0);
    step(4'h6, 1, 0, 2'd3, 32'h0);
    n_checks++; if (bus.avs_readdata !== 32'h1) begin n_fail++; $display("FAIL race_count: got %h expected 1", bus.avs_readdata); end
    step(4'h6, 0, 1, 2'd2, 32'h0);
    step(4'h6, 1, 0, 2'd2, 32'h0);
    n_checks++; if (bus.avs_readdata !== 32'h9) begin n_fail++; $display("FAIL race_write0: got %h expected 9", bus.avs_readdata); end
  endtask

  task automatic test_wrap();
    step(4'hF, 0, 1, 2'd3, 32'h0);
    step(4'hF, 0, 1, 2'd2, 32'hF);
    for (int i = 0; i < 256; i++) begin
      step(4'hD, 0, 0, 2'd0, 32'h0);
      step(4'hF, 0, 0, 2'd0, 32'h0);
    end
    step(4'hF, 1, 0, 2'd3, 32'h0);
    n_checks++; if (bus.avs_readdata !== 32'h0) begin n_fail++; $display("FAIL wrap_count: got %h expected 0", bus.avs_readdata); end
    step(4'hF, 1, 0, 2'd2, 32'h0);
    n_checks++; if (bus.avs_readdata !== 32'h2) begin n_fail++; $display("FAIL wrap_capture: got %h expected 2", bus.avs_readdata); end
    step(4'h0, 0, 0, 2'd0, 32'h0);
    step(4'h0, 0, 1, 2'd3, 32'h0);
    step(4'h0, 0, 1, 2'd2, 32'hF);
    repeat (5) step(4'hF, 0, 0, 2'd0, 32'h0);
    step(4'hF, 1, 0, 2'd3, 32'h0);
    n_checks++; if (bus.avs_readdata !== 32'h0) begin n_fail++; $display("FAIL release_count: got %h expected 0", bus.avs_readdata); end
    step(4'hF, 1, 0, 2'd2, 32'h0);
    n_checks++; if (bus.avs_readdata !== 32'h0) begin n_fail++; $display("FAIL release_capture: got %h expected 0", bus.avs_readdata); end
  endtask

  task automatic test_upper_bits();
    step(4'h7, 0, 0, 2'd0, 32'h0);
    step(4'h7, 0, 1, 2'd2, 32'hFFFF_F000);
    step(4'h7, 1, 0, 2'd2, 32'h0);
    n_checks++; if (bus.avs_readdata !== m_rd) begin n_fail++; $display("FAIL upper_capture: got %h expected %h", bus.avs_readdata, m_rd); end
    n_checks++; if (bus.avs_readdata[31:12] !== 20'h0) begin n_fail++; $display("FAIL upper_zero: got %h expected 0", bus.avs_readdata[31:12]); end
  endtask

`ifdef KEY_LONGPRESS_EN
  task automatic test_longpress();
    step(4'hF, 0, 1, 2'd2, 32'hFFF);
    step(4'hF, 0, 1, 2'd1, 32'h4);
    repeat (9) step(4'hB, 0, 0, 2'd0, 32'h0);
    step(4'hF, 0, 1, 2'd2, 32'h4);
    step(4'hF, 1, 0, 2'd2, 32'h0);
    n_checks++; if (bus.avs_readdata[10] !== 1'b0) begin n_fail++; $display("FAIL long_9: got %b expected 0", bus.avs_readdata[10]); end
    repeat (10) step(4'hB, 0, 0, 2'd0, 32'h0);
    step(4'hF, 0, 1, 2'd2, 32'h4);
    step(4'hF, 1, 0, 2'd2, 32'h0);
    n_checks++; if (bus.avs_readdata[10] !== 1'b1) begin n_fail++; $display("FAIL long_10: got %b expected 1", bus.avs_readdata[10]); end
    n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL long_irq: got %b expected 1", irq); end
    step(4'hF, 0, 1, 2'd2, 32'h400);
    for (int i = 0; i < 1000; i++) begin
      step(4'hB, i == 499, i == 500, 2'd2, (i == 500) ? 32'h400 : 32'h0);
      if (i == 499) begin
        n_checks++; if (bus.avs_readdata[10] !== 1'b1) begin n_fail++; $display("FAIL long_1000_set: got %b expected 1", bus.avs_readdata[10]); end
      end
    end
    step(4'hB, 1, 0, 2'd2, 32'h0);
    n_checks++; if (bus.avs_readdata[10] !== 1'b0) begin n_fail++; $display("FAIL long_once: got %b expected 0", bus.avs_readdata[10]); end
    n_checks++; if (bus.avs_readdata !== m_rd) begin n_fail++; $display("FAIL long_model: got %h expected %h", bus.avs_readdata, m_rd); end
  endtask
`endif

  task automatic test_random();
    logic [3:0] d;
    bit rd, wr;
    d = 4'hF;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 2) == 0) d = 4'($urandom);
      rd = $urandom_range(0, 1) == 1;
      wr = $urandom_range(0, 3) == 0;
      step(d, rd, wr, 2'($urandom), $urandom);
      n_checks++; if (irq !== m_irq()) begin n_fail++; $display("FAIL random_irq cycle %0d: got %b expected %b", i, irq, m_irq()); end
      if (rd) begin
        n_checks++; if (bus.avs_readdata !== m_rd) begin n_fail++; $display("FAIL random_read cycle %0d: got %h expected %h", i, bus.avs_readdata, m_rd); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_press();
    test_multi();
    test_race();
    test_wrap();
    test_upper_bits();
`ifdef KEY_LONGPRESS_EN
    test_longpress();
`endif
    test_random();
    step(4'h0, 0, 1, 2'd1, 32'hF);
    test_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
